cga_line_doubler: RTL and testbench

//  Scan-doubler stage directly downstream of the CGA pixel pusher and CRTC.

---
 rtl/cga_line_doubler.sv | 157 +++++++++++++++
 tb/tb_cga_line_doubler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cga_line_doubler.sv
// Scan doubler for CGA video: captures each source line at half clock rate into one bank of a
// ping-pong buffer while the previous line is replayed twice at full clock rate from the other.
module cga_line_doubler #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [3:0]        video,
    input  logic              hsync,
    input  logic              line_reset,
    output logic [3:0]        dbl_video,
    output logic              dbl_hsync,
    output logic [ADDR_W-1:0] line_len,
    output logic              overflow
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] AddrMax = '1;
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StPass0,
        StPass1
    } state_e;

    state_e            state_q, state_d;
    logic              line_reset_q;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] line_len_q, line_len_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [4:0]        rd_data_q;
    logic [4:0]        out_q, out_d;

    logic              line_ev;
    logic              wr_en;
    logic [ADDR_W:0]   wr_idx;
    logic [ADDR_W:0]   rd_idx;
    logic [4:0]        wr_data;

    // Two banks of {hsync, video}; bank select is the MSB of the index.
    logic [4:0] mem [0:2*Depth-1];

    assign line_ev = line_reset & ~line_reset_q;
    assign wr_data = {hsync, video};
    assign rd_idx  = {~wr_bank_q, rd_addr_q};

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_addr_d  = wr_addr_q;
        wr_bank_d  = wr_bank_q;
        line_len_d = line_len_q;
        overflow_d = overflow_q;
        rd_addr_d  = rd_addr_q;
        wr_en      = 1'b0;
        wr_idx     = {wr_bank_q, wr_addr_q};

        if (line_ev) begin
            // This cycle's sample opens the new line at address 0 of the freshly swapped bank.
            line_len_d = wr_addr_q;
            wr_bank_d  = ~wr_bank_q;
            wr_addr_d  = AddrOne;
            phase_d    = 1'b1;
            rd_addr_d  = '0;
            state_d    = (wr_addr_q != '0) ? StPass0 : StIdle;
            wr_en      = 1'b1;
            wr_idx     = {~wr_bank_q, {ADDR_W{1'b0}}};
        end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                wr_en = 1'b1;
                if (wr_addr_q == AddrMax) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + AddrOne;
                end
            end

            unique case (state_q)
                StIdle: begin
                    rd_addr_d = '0;
                end
                StPass0: begin
                    if (rd_addr_q == line_len_q - AddrOne) begin
                        rd_addr_d = '0;
                        state_d   = StPass1;
                    end else begin
                        rd_addr_d = rd_addr_q + AddrOne;
                    end
                end
                StPass1: begin
                    if (rd_addr_q == line_len_q - AddrOne) begin
                        rd_addr_d = '0;
                        state_d   = StIdle;
                    end else begin
                        rd_addr_d = rd_addr_q + AddrOne;
                    end
                end
                default: begin
                    rd_addr_d = '0;
                    state_d   = StIdle;
                end
            endcase
        end
    end

    // Valid flag travels with the read so an idle replay blanks the output.
    always_comb begin
        rd_valid_d = (state_q != StIdle);
        out_d      = rd_valid_q ? rd_data_q : 5'd0;
    end

    // Read-first: on a line event the old line's final read still returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data_q <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q      <= StIdle;
            line_reset_q <= 1'b0;
            phase_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_bank_q    <= 1'b0;
            line_len_q   <= '0;
            overflow_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            out_q        <= 5'd0;
        end else begin
            state_q      <= state_d;
            line_reset_q <= line_reset;
            phase_q      <= phase_d;
            wr_addr_q    <= wr_addr_d;
            wr_bank_q    <= wr_bank_d;
            line_len_q   <= line_len_d;
            overflow_q   <= overflow_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= rd_valid_d;
            out_q        <= out_d;
        end
    end

    assign dbl_video = out_q[3:0];
    assign dbl_hsync = out_q[4];
    assign line_len  = line_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cga_line_doubler.sv
// Randomised bench for cga_line_doubler: a cycle-indexed table of expected output samples is
// built from captured lines, and every cycle's outputs are compared against it.
module tb_cga_line_doubler;

    localparam int AW   = 4;
    localparam int D    = 2 ** AW;
    localparam int MAXC = 16384;

    logic          clk = 1'b0;
    logic          reset_l;
    logic [3:0]    video;
    logic          hsync;
    logic          line_reset;
    logic [3:0]    dbl_video;
    logic          dbl_hsync;
    logic [AW-1:0] line_len;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected {hsync, video} at the output in each cycle.
    logic [4:0]  exp_out [0:MAXC-1];
    int          exp_len;
    bit          exp_ovf;
    logic [4:0]  cur_line [$];
    bit          m_phase;
    bit          m_prev_lr;

    always #5 clk = ~clk;

    cga_line_doubler #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .video      (video),
        .hsync      (hsync),
        .line_reset (line_reset),
        .dbl_video  (dbl_video),
        .dbl_hsync  (dbl_hsync),
        .line_len   (line_len),
        .overflow   (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic zero_from(input int first);
        for (int i = first; i < first + 2 * D + 8; i++) begin
            if (i < MAXC) exp_out[i] = 5'd0;
        end
    endtask

    // Applies the rules to the inputs just sampled at the clock edge ending cycle 'cyc'.
    task automatic model_edge();
        logic [4:0] s;
        int         n;
        s = {hsync, video};
        if (!reset_l) begin
            zero_from(cyc + 1);
            cur_line.delete();
            m_phase   = 1'b0;
            m_prev_lr = 1'b0;
            exp_len   = 0;
            exp_ovf   = 1'b0;
        end else begin
            if (line_reset && !m_prev_lr) begin
                n = (cur_line.size() > D - 1) ? D - 1 : cur_line.size();
                exp_len = n;
                zero_from(cyc + 3);
                for (int i = 0; i < 2 * n; i++) begin
                    if (cyc + 3 + i < MAXC) exp_out[cyc + 3 + i] = cur_line[i % n];
                end
                cur_line.delete();
                cur_line.push_back(s);
                m_phase = 1'b1;
            end else begin
                if (!m_phase) begin
                    cur_line.push_back(s);
                    if (cur_line.size() >= D) exp_ovf = 1'b1;
                end
                m_phase = !m_phase;
            end
            m_prev_lr = line_reset;
        end
    endtask

    task automatic step(input logic rl, input logic lr, input logic [3:0] v, input logic h);
        reset_l    = rl;
        line_reset = lr;
        video      = v;
        hsync      = h;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_eq("dbl_video", 32'(dbl_video), 32'(exp_out[cyc][3:0]));
        check_eq("dbl_hsync", 32'(dbl_hsync), 32'(exp_out[cyc][4]));
        check_eq("line_len", 32'(line_len), 32'(exp_len));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // One source line: event on the first cycle, each sample held for two clocks.
    task automatic send_line(input int n, input int hs_lo, input int hs_hi, input bit rnd);
        logic [3:0] v;
        logic       h;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 4'($urandom) : 4'(i + 1);
            h = (i >= hs_lo && i <= hs_hi);
            step(1'b1, (i == 0), v, h);
            step(1'b1, 1'b0, v, h);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        logic lr;
        for (int i = 0; i < MAXC; i++) exp_out[i] = 5'd0;
        exp_len   = 0;
        exp_ovf   = 1'b0;
        m_phase   = 1'b0;
        m_prev_lr = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom));

        // Event straight after reset: zero-length line stays blank.
        step(1'b1, 1'b1, 4'd9, 1'b0);
        step(1'b1, 1'b0, 4'd9, 1'b0);

        // Basic ramp, then the same with hsync on samples 6 and 7.
        send_line(8, -1, -1, 1'b0);
        send_line(8, 5, 6, 1'b0);
        send_line(1, -1, -1, 1'b1);
        send_line(1, 0, 0, 1'b1);
        send_line(3, -1, -1, 1'b1);
        idle(30);

        // Overflow: 20 samples into a 16-deep bank.
        send_line(20, 2, 4, 1'b1);
        send_line(4, -1, -1, 1'b1);
        send_line(6, 1, 1, 1'b1);
        idle(40);

        // Reset in the middle of the second pass of an 8-sample line.
        send_line(8, 3, 3, 1'b1);
        step(1'b1, 1'b1, 4'($urandom), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'($urandom), 1'($urandom));
        step(1'b0, 1'b0, 4'd5, 1'b1);
        send_line(5, 0, 1, 1'b1);
        send_line(2, -1, -1, 1'b1);
        idle(30);

        // Fully random traffic, including odd line lengths and rare resets.
        lr = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 24) == 0) lr = ~lr;
            else if (lr && $urandom_range(0, 2) == 0) lr = 1'b0;
            step(($urandom_range(0, 899) != 0), lr, 4'($urandom), 1'($urandom));
        end
        idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
